// File: rtl/lte_dl_trans_ctrl.sv
// -----------------------------------------------------------------------------
// lte_dl_trans_ctrl
//
// Control block for the LTE downlink path-transpose stage.
//  * Supervises the raw frame header and locks a flywheel frame timer to it
//    (SEARCH -> VERIFY -> LOCK).
//  * Regenerates a clean one-cycle frame header pulse while locked.
//  * Owns the 8 x 3-bit antenna-position map. Writes go to a shadow copy. A
//    commit moves the shadow copy into the active map only on a frame boundary
//    while locked, so the RAM write-address pattern never changes mid-frame.
//    When the timer is not locked, the commit takes effect on the next clock.
//
// Optional feature (macro ANT_MAP_CHECK_EN):
//    When this macro is defined, the shadow map must be a permutation of 0..7
//    at transfer time. If it is not, the transfer is dropped, the pending flag
//    still clears, and o_cfg_err pulses for one cycle. When the macro is not
//    defined, every commit transfers and o_cfg_err is tied low.
//
// Ports:
//   clk            datapath clock
//   asy_rst        asynchronous active-high reset
//   i_fram_hd      raw frame header pulse
//   cfg_wr         shadow map write strobe (cfg_addr / cfg_wdata)
//   cfg_addr       shadow entry index
//   cfg_wdata      antenna position for that entry
//   cfg_commit     request a shadow -> active transfer
//   o_fram_hd      regenerated frame header pulse (LOCK only)
//   o_ant_posinfo  active map; entry i in [4i+2:4i], bit 4i+3 is always 0
//   o_locked       timer locked
//   o_hd_err       one-cycle pulse per out-of-window header
//   o_cfg_pending  commit waiting for a boundary
//   o_cfg_err      commit rejected (optional feature)
// -----------------------------------------------------------------------------
module lte_dl_trans_ctrl #(
  parameter logic [23:0] FRAME_LEN = 24'd3686399,
  parameter int          TOL       = 4,
  parameter int          LOCK_CNT  = 3,
  parameter int          MISS_MAX  = 3
) (
  input  logic        clk,
  input  logic        asy_rst,
  input  logic        i_fram_hd,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [2:0]  cfg_wdata,
  input  logic        cfg_commit,
  output logic        o_fram_hd,
  output logic [31:0] o_ant_posinfo,
  output logic        o_locked,
  output logic        o_hd_err,
  output logic        o_cfg_pending,
  output logic        o_cfg_err
);

  localparam logic [23:0] TOL_W    = 24'(TOL);
  localparam logic [23:0] WIN_LO   = FRAME_LEN - TOL_W;
  localparam logic [23:0] WIN_HI   = FRAME_LEN + TOL_W;
  localparam logic [23:0] FCNT_SAT = WIN_HI + 24'd1;
  // The "header seen" flag is cleared one count before the early window opens.
  localparam logic [23:0] HD_CLR   = WIN_LO - 24'd1;
  localparam logic [3:0]  LOCK_W   = 4'(LOCK_CNT);
  localparam logic [3:0]  MISS_W   = 4'(MISS_MAX);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [23:0] fcnt_reg, fcnt_next;
  logic [2:0]  good_cnt_reg, good_cnt_next;
  logic [2:0]  miss_cnt_reg, miss_cnt_next;
  logic        hd_ok_reg, hd_ok_next;      // header accepted since the early window opened
  logic        late_ok_reg, late_ok_next;  // late window armed by a header-less wrap
  logic        fram_hd_reg, fram_hd_next;
  logic        hd_err_reg, hd_err_next;
  logic        sync;
  logic        tol_miss;
  logic [3:0]  miss_sum;
  logic [3:0]  good_inc;
  logic        in_verify_win, in_early, at_end, in_late;

  assign good_inc      = {1'b0, good_cnt_reg} + 4'd1;
  assign in_verify_win = (fcnt_reg >= WIN_LO) && (fcnt_reg <= WIN_HI);
  assign in_early      = (fcnt_reg >= WIN_LO) && (fcnt_reg < FRAME_LEN);
  assign at_end        = (fcnt_reg == FRAME_LEN);
  assign in_late       = late_ok_reg && (fcnt_reg < TOL_W);

  // ---------------------------------------------------------------------------
  // Frame timer FSM: next state and next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    hd_ok_next    = hd_ok_reg;
    late_ok_next  = late_ok_reg;
    fram_hd_next  = 1'b0;
    hd_err_next   = 1'b0;
    sync          = 1'b0;
    tol_miss      = 1'b0;
    miss_sum      = 4'd0;
    fcnt_next     = fcnt_reg;

    case (state_reg)
      SEARCH: begin
        if (i_fram_hd) begin
          state_next    = VERIFY;
          good_cnt_next = 3'd0;
          sync          = 1'b1;
        end
      end

      VERIFY: begin
        if (i_fram_hd) begin
          sync = 1'b1;
          if (in_verify_win) begin
            if (good_inc == LOCK_W) begin
              state_next    = LOCK;
              good_cnt_next = 3'd0;
              miss_cnt_next = 3'd0;
              hd_ok_next    = 1'b1;
              late_ok_next  = 1'b0;
            end else begin
              good_cnt_next = good_inc[2:0];
            end
          end else begin
            hd_err_next   = 1'b1;
            good_cnt_next = 3'd0;
          end
        end else if (fcnt_reg > WIN_HI) begin
          state_next = SEARCH;
        end
      end

      LOCK: begin
        if (at_end) begin
          // Flywheel wrap. An on-time header here counts as accepted.
          sync         = 1'b1;
          fram_hd_next = 1'b1;
          if (i_fram_hd) begin
            hd_ok_next    = 1'b1;
            miss_cnt_next = 3'd0;
            late_ok_next  = 1'b0;
          end else begin
            late_ok_next  = 1'b1;
          end
        end else if (i_fram_hd && in_early) begin
          // An early header replaces the wrap, so there is still one pulse per frame.
          sync          = 1'b1;
          fram_hd_next  = 1'b1;
          hd_ok_next    = 1'b1;
          miss_cnt_next = 3'd0;
          late_ok_next  = 1'b0;
        end else if (i_fram_hd && in_late) begin
          // A late header realigns the timer. The wrap already produced this frame's pulse.
          sync          = 1'b1;
          hd_ok_next    = 1'b1;
          miss_cnt_next = 3'd0;
          late_ok_next  = 1'b0;
        end else begin
          if (i_fram_hd) begin
            hd_err_next = 1'b1;
          end
          if (fcnt_reg == TOL_W) begin
            tol_miss     = ~hd_ok_reg;
            late_ok_next = 1'b0;
          end
          if (fcnt_reg == HD_CLR) begin
            hd_ok_next = 1'b0;
          end
          miss_sum = {1'b0, miss_cnt_reg} + {3'd0, i_fram_hd} + {3'd0, tol_miss};
          if (miss_sum >= MISS_W) begin
            state_next    = SEARCH;
            miss_cnt_next = 3'd0;
          end else begin
            miss_cnt_next = miss_sum[2:0];
          end
        end
      end

      default: begin
        state_next = SEARCH;
      end
    endcase

    // The counter saturates while unlocked. In LOCK it wraps at FRAME_LEN and
    // never reaches the saturation value.
    if (sync) begin
      fcnt_next = 24'd0;
    end else if (fcnt_reg == FCNT_SAT) begin
      fcnt_next = FCNT_SAT;
    end else begin
      fcnt_next = fcnt_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      state_reg    <= SEARCH;
      fcnt_reg     <= 24'd0;
      good_cnt_reg <= 3'd0;
      miss_cnt_reg <= 3'd0;
      hd_ok_reg    <= 1'b0;
      late_ok_reg  <= 1'b0;
      fram_hd_reg  <= 1'b0;
      hd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fcnt_reg     <= fcnt_next;
      good_cnt_reg <= good_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      hd_ok_reg    <= hd_ok_next;
      late_ok_reg  <= late_ok_next;
      fram_hd_reg  <= fram_hd_next;
      hd_err_reg   <= hd_err_next;
    end
  end

  assign o_fram_hd = fram_hd_reg;
  assign o_hd_err  = hd_err_reg;
  assign o_locked  = (state_reg == LOCK);

  // ---------------------------------------------------------------------------
  // Antenna-position map: shadow and active copies
  // ---------------------------------------------------------------------------
  logic [2:0] shadow_reg [8];
  logic [2:0] active_reg [8];
  logic       pending_reg;
  logic       xfer;
  logic       xfer_ok;
  logic       perm_ok;

  // While locked, the transfer happens on the edge that raises o_fram_hd.
  // Otherwise it happens on the clock after the commit request.
  assign xfer    = pending_reg && ((state_reg != LOCK) || fram_hd_next);
  assign xfer_ok = xfer && perm_ok;

  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow_reg[i] <= 3'(i);
        active_reg[i] <= 3'(i);
      end
      pending_reg <= 1'b0;
    end else begin
      // The transfer reads the pre-write shadow. A write on the same edge
      // lands only in the shadow copy.
      if (cfg_wr) begin
        shadow_reg[cfg_addr] <= cfg_wdata;
      end
      if (xfer_ok) begin
        for (int i = 0; i < 8; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
      if (xfer) begin
        pending_reg <= 1'b0;
      end else if (cfg_commit) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign o_cfg_pending = pending_reg;

`ifdef ANT_MAP_CHECK_EN
  logic [7:0] present;
  logic       cfg_err_reg;

  // Every value 0..7 must appear exactly once. With eight entries, full
  // coverage of the values is the same as having no duplicates.
  always_comb begin
    present = 8'd0;
    for (int i = 0; i < 8; i++) begin
      present[shadow_reg[i]] = 1'b1;
    end
  end
  assign perm_ok = &present;

  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= xfer && !perm_ok;
    end
  end
  assign o_cfg_err = cfg_err_reg;
`else
  assign perm_ok   = 1'b1;
  assign o_cfg_err = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pack
      assign o_ant_posinfo[4*gi +: 4] = {1'b0, active_reg[gi]};
    end
  endgenerate

endmodule
